// File: rtl/ahb_lite_pkg.sv
// rtl/ahb_lite_pkg.sv - shared AHB-Lite encodings, FSM states and decode helpers
package ahb_lite_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        SIZE_BYTE  = 3'd0,
        SIZE_HALF  = 3'd1,
        SIZE_WORD  = 3'd2,
        SIZE_DWORD = 3'd3,
        SIZE_128   = 3'd4,
        SIZE_256   = 3'd5,
        SIZE_512   = 3'd6,
        SIZE_1024  = 3'd7
    } hsize_t;

    typedef enum logic {
        RESP_OKAY  = 1'b0,
        RESP_ERROR = 1'b1
    } hresp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        ERR1 = 2'd2,
        ERR2 = 2'd3
    } state_t;

    // NONSEQ and SEQ carry a real transfer; IDLE and BUSY never do.
    function automatic logic is_active(input logic [1:0] htrans);
        return (htrans == TRANS_NONSEQ) || (htrans == TRANS_SEQ);
    endfunction

    // A transfer of 2**size bytes must start on a 2**size byte boundary.
    function automatic logic size_aligned(input logic [7:0] addr_lo, input logic [2:0] size);
        logic [7:0] mask;
        mask = (8'd1 << size) - 8'd1;
        return (addr_lo & mask) == 8'd0;
    endfunction

endpackage

// File: rtl/ahb_lite_mem_array.sv
// rtl/ahb_lite_mem_array.sv - word memory with byte-enable write and asynchronous read
module ahb_lite_mem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   addr,
    input  logic [DATA_W/8-1:0]        be,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-lane write; contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_lite_mem_slave.sv
// rtl/ahb_lite_mem_slave.sv - AHB-Lite memory slave with wait states and ERROR response
module ahb_lite_mem_slave
    import ahb_lite_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 32,
    parameter int                DEPTH       = 1024,
    parameter int                WAIT_STATES = 0,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              hsel,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [2:0]        hburst,
    input  logic [3:0]        hprot,
    input  logic [DATA_W-1:0] hwdata,
    input  logic              hready,
    output logic              hreadyout,
    output logic              hresp,
    output logic [DATA_W-1:0] hrdata
);

    localparam int         NB       = DATA_W / 8;
    localparam int         LANE_W   = $clog2(NB);
    localparam int         IDX_W    = $clog2(DEPTH);
    localparam int         OFF_W    = LANE_W + IDX_W;
    localparam logic [2:0] MAX_SIZE = 3'(LANE_W);
    localparam logic [2:0] WS       = 3'(WAIT_STATES);

    state_t            state, next_state;
    logic [2:0]        count, next_count;
    logic [IDX_W-1:0]  idx_q;
    logic [NB-1:0]     be_q, be_d;
    logic              write_q;
    logic              in_range, valid, slot_free, take, mem_we;
    logic [DATA_W-1:0] rd_word;
    logic              unused_bits;

    // Burst type and protection are accepted on the bus but carry no meaning here.
    assign unused_bits = ^{hburst, hprot};

    // Region is aligned to its own size, so a tag compare on the upper bits suffices.
    assign in_range  = haddr[ADDR_W-1:OFF_W] == BASE_ADDR[ADDR_W-1:OFF_W];
    assign valid     = in_range && (hsize <= MAX_SIZE) && size_aligned(haddr[7:0], hsize);
    assign slot_free = (state == IDLE) || (state == ERR2) || ((state == DATA) && (count == WS));
    assign take      = slot_free && hsel && hready && is_active(htrans);

    // Little-endian lane select: lanes sharing the access's size-aligned chunk.
    always_comb begin
        be_d = '0;
        for (int i = 0; i < NB; i++) begin
            be_d[i] = (i >> hsize) == (int'(haddr[LANE_W-1:0]) >> hsize);
        end
    end

    // Next-state and wait counter; completion points may chain straight into a new transfer.
    always_comb begin
        next_state = state;
        next_count = count;
        mem_we     = 1'b0;
        case (state)
            IDLE: next_state = IDLE;
            DATA: begin
                if (count != WS) begin
                    next_count = count + 3'd1;
                end else begin
                    mem_we = write_q;
                end
            end
            ERR1:    next_state = ERR2;
            ERR2:    next_state = ERR2;
            default: next_state = IDLE;
        endcase
        if (slot_free) begin
            next_count = '0;
            if (take) begin
                next_state = valid ? DATA : ERR1;
            end else begin
                next_state = IDLE;
            end
        end
    end

    // State register and address-phase capture.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state   <= IDLE;
            count   <= '0;
            write_q <= 1'b0;
            idx_q   <= '0;
            be_q    <= '0;
        end else begin
            state <= next_state;
            count <= next_count;
            if (take) begin
                write_q <= hwrite;
                idx_q   <= haddr[OFF_W-1:LANE_W];
                be_q    <= be_d;
            end
        end
    end

    assign hreadyout = slot_free;
    assign hresp     = ((state == ERR1) || (state == ERR2)) ? RESP_ERROR : RESP_OKAY;
    assign hrdata    = ((state == DATA) && !write_q) ? rd_word : '0;

    ahb_lite_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (hclk),
        .we    (mem_we),
        .addr  (idx_q),
        .be    (be_q),
        .wdata (hwdata),
        .rdata (rd_word)
    );

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// tb/tb_ahb_lite_mem_slave.sv - scoreboard bench for ahb_lite_mem_slave, zero and two wait states
module tb_ahb_lite_mem_slave;
    import ahb_lite_pkg::*;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic        hready_low;
    logic        sel2;

    logic        hsel0, hsel2, hready0, hready2;
    logic        hreadyout0, hreadyout2, hresp0, hresp2;
    logic [31:0] hrdata0, hrdata2;
    logic        cur_ready, cur_resp;
    logic [31:0] cur_rdata;

    int errors = 0;
    int checks = 0;

    always #5 hclk = ~hclk;

    assign hsel0     = hsel & ~sel2;
    assign hsel2     = hsel & sel2;
    assign hready0   = ~hready_low & hreadyout0;
    assign hready2   = ~hready_low & hreadyout2;
    assign cur_ready = sel2 ? hreadyout2 : hreadyout0;
    assign cur_resp  = sel2 ? hresp2 : hresp0;
    assign cur_rdata = sel2 ? hrdata2 : hrdata0;

    ahb_lite_mem_slave #(
        .DATA_W(32), .ADDR_W(32), .DEPTH(1024), .WAIT_STATES(0), .BASE_ADDR(32'h0)
    ) u_dut0 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
        .hready(hready0), .hreadyout(hreadyout0), .hresp(hresp0), .hrdata(hrdata0)
    );

    ahb_lite_mem_slave #(
        .DATA_W(32), .ADDR_W(32), .DEPTH(1024), .WAIT_STATES(2), .BASE_ADDR(32'h0)
    ) u_dut2 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel2), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
        .hready(hready2), .hreadyout(hreadyout2), .hresp(hresp2), .hrdata(hrdata2)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] data;
        bit          stall;
        bit          seq;
    } xfer_t;

    typedef struct {
        bit          wr;
        bit          err;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    xfer_t       txq[$];
    exp_t        sbq[$];
    logic [31:0] model0 [int];
    logic [31:0] model2 [int];

    task automatic add(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] data, input bit stall = 1'b0, input bit seq = 1'b0);
        xfer_t x;
        x.wr = wr; x.addr = addr; x.size = size; x.data = wr ? data : 32'h0;
        x.stall = stall; x.seq = seq;
        txq.push_back(x);
    endtask

    // Reference model: 4 KiB window at 0, 32-bit bus, little-endian lanes.
    task automatic predict(input xfer_t x, output exp_t e);
        logic [31:0] w;
        int          idx, off, nbytes;
        e.wr = x.wr; e.addr = x.addr; e.wdata = x.data; e.rdata = 32'h0;
        e.err = (x.addr >= 32'd4096) || (x.size > 3'd2) || ((x.addr % (32'd1 << x.size)) != 32'd0);
        if (!e.err) begin
            idx = int'(x.addr >> 2);
            if (sel2) w = model2.exists(idx) ? model2[idx] : 32'hx;
            else      w = model0.exists(idx) ? model0[idx] : 32'hx;
            if (x.wr) begin
                off    = int'(x.addr[1:0]);
                nbytes = 1 << x.size;
                for (int b = 0; b < 4; b++) begin
                    if (b >= off && b < off + nbytes) w[8*b +: 8] = x.data[8*b +: 8];
                end
                if (sel2) model2[idx] = w;
                else      model0[idx] = w;
            end else begin
                e.rdata = w;
            end
        end
    endtask

    // Drives txq as a pipelined master; each completed data phase is checked against sbq.
    task automatic run_seq(input string tag);
        int    guard = 0;
        int    waits = 0;
        int    exp_waits;
        xfer_t x;
        exp_t  e, c;
        while ((txq.size() > 0 || sbq.size() > 0) && guard < 500) begin
            @(negedge hclk);
            guard++;
            hready_low = 1'b0;
            if (sbq.size() > 0) begin
                c = sbq[0];
                hwdata = c.wdata;
                if (cur_ready) begin
                    exp_waits = c.err ? 1 : (sel2 ? 2 : 0);
                    checks++;
                    if (waits !== exp_waits) begin
                        errors++;
                        $display("FAIL %s wait_cycles addr=%h got %0d exp %0d", tag, c.addr, waits, exp_waits);
                    end
                    checks++;
                    if (cur_resp !== c.err) begin
                        errors++;
                        $display("FAIL %s hresp addr=%h got %b exp %b", tag, c.addr, cur_resp, c.err);
                    end
                    if (!c.wr) begin
                        checks++;
                        if (cur_rdata !== c.rdata) begin
                            errors++;
                            $display("FAIL %s hrdata addr=%h got %h exp %h", tag, c.addr, cur_rdata, c.rdata);
                        end
                    end
                    c = sbq.pop_front();
                    waits = 0;
                end else begin
                    waits++;
                    checks++;
                    if (cur_resp !== c.err) begin
                        errors++;
                        $display("FAIL %s wait_hresp addr=%h got %b exp %b", tag, c.addr, cur_resp, c.err);
                    end
                    if (waits > 8) begin
                        errors++;
                        $display("FAIL %s timeout addr=%h hreadyout stuck low", tag, c.addr);
                        sbq.delete();
                        waits = 0;
                    end
                end
            end else begin
                checks++;
                if (cur_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL %s idle_hreadyout got %b exp 1", tag, cur_ready);
                end
            end
            hsel   = 1'b0;
            htrans = TRANS_IDLE;
            if (sbq.size() == 0 && txq.size() > 0) begin
                x      = txq[0];
                hsel   = 1'b1;
                haddr  = x.addr;
                hwrite = x.wr;
                hsize  = x.size;
                htrans = x.seq ? TRANS_SEQ : TRANS_NONSEQ;
                if (x.stall) begin
                    hready_low = 1'b1;
                    x.stall    = 1'b0;
                    txq[0]     = x;
                end else begin
                    x = txq.pop_front();
                    predict(x, e);
                    sbq.push_back(e);
                end
            end
        end
        if (guard >= 500) begin
            errors++;
            $display("FAIL %s sequence_budget exhausted", tag);
            txq.delete();
            sbq.delete();
        end
        @(negedge hclk);
        hsel = 1'b0; htrans = TRANS_IDLE; hready_low = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (hreadyout0 !== 1'b1) begin errors++; $display("FAIL reset hreadyout0 got %b exp 1", hreadyout0); end
        checks++; if (hresp0 !== 1'b0)     begin errors++; $display("FAIL reset hresp0 got %b exp 0", hresp0); end
        checks++; if (hrdata0 !== 32'h0)   begin errors++; $display("FAIL reset hrdata0 got %h exp 0", hrdata0); end
        checks++; if (hreadyout2 !== 1'b1) begin errors++; $display("FAIL reset hreadyout2 got %b exp 1", hreadyout2); end
        checks++; if (hresp2 !== 1'b0)     begin errors++; $display("FAIL reset hresp2 got %b exp 0", hresp2); end
        checks++; if (hrdata2 !== 32'h0)   begin errors++; $display("FAIL reset hrdata2 got %h exp 0", hrdata2); end
    endtask

    task automatic test_zero_wait();
        sel2 = 1'b0;
        add(1, 32'h10, SIZE_WORD, 32'hDEADBEEF);
        add(0, 32'h10, SIZE_WORD, 32'h0);
        add(1, 32'h3FC, SIZE_WORD, 32'h5A5AA5A5);
        add(0, 32'h3FC, SIZE_WORD, 32'h0);
        run_seq("zero_wait");
    endtask

    task automatic test_wait_states();
        sel2 = 1'b1;
        add(1, 32'h10, SIZE_WORD, 32'h12345678);
        add(0, 32'h10, SIZE_WORD, 32'h0);
        add(1, 32'hFFC, SIZE_WORD, 32'h0F1E2D3C);
        add(0, 32'hFFC, SIZE_WORD, 32'h0);
        run_seq("wait_states");
    endtask

    task automatic test_byte_lanes();
        sel2 = 1'b0;
        add(1, 32'h10, SIZE_WORD, 32'h00000000);
        add(1, 32'h13, SIZE_BYTE, 32'hAA000000);
        add(0, 32'h10, SIZE_WORD, 32'h0);
        add(1, 32'h14, SIZE_WORD, 32'h11223344);
        add(1, 32'h16, SIZE_HALF, 32'hBEEF0000);
        add(1, 32'h14, SIZE_BYTE, 32'h000000C3);
        add(0, 32'h14, SIZE_WORD, 32'h0);
        run_seq("byte_lanes");
    endtask

    task automatic test_errors();
        sel2 = 1'b0;
        add(0, 32'h1000, SIZE_WORD, 32'h0);
        add(0, 32'h01, SIZE_HALF, 32'h0);
        add(1, 32'h01, SIZE_HALF, 32'hFFFFFFFF);
        add(1, 32'h10, SIZE_DWORD, 32'hFFFFFFFF);
        add(1, 32'h12, SIZE_WORD, 32'hFFFFFFFF);
        add(0, 32'h10, SIZE_WORD, 32'h0);
        run_seq("errors_ws0");
        sel2 = 1'b1;
        add(0, 32'h1000, SIZE_WORD, 32'h0);
        add(1, 32'h2000, SIZE_WORD, 32'h77777777);
        add(0, 32'h10, SIZE_WORD, 32'h0);
        run_seq("errors_ws2");
    endtask

    task automatic test_burst_stall();
        sel2   = 1'b1;
        hburst = 3'b011;
        add(1, 32'h20, SIZE_WORD, 32'hA0A0A0A0, 1'b0, 1'b0);
        add(1, 32'h24, SIZE_WORD, 32'hB1B1B1B1, 1'b1, 1'b1);
        add(1, 32'h28, SIZE_WORD, 32'hC2C2C2C2, 1'b0, 1'b1);
        add(1, 32'h2C, SIZE_WORD, 32'hD3D3D3D3, 1'b1, 1'b1);
        run_seq("burst_write");
        hburst = 3'b000;
        add(0, 32'h1004, SIZE_WORD, 32'h0, 1'b1, 1'b0);
        add(0, 32'h20, SIZE_WORD, 32'h0);
        add(0, 32'h24, SIZE_WORD, 32'h0, 1'b1, 1'b0);
        add(0, 32'h28, SIZE_WORD, 32'h0);
        add(0, 32'h2C, SIZE_WORD, 32'h0, 1'b1, 1'b0);
        run_seq("burst_read");
    endtask

    task automatic test_reset_midflight();
        sel2 = 1'b1;
        add(1, 32'h40, SIZE_WORD, 32'hCAFEF00D);
        run_seq("reset_setup");
        hsel = 1'b1; haddr = 32'h40; hwrite = 1'b1; hsize = SIZE_WORD; htrans = TRANS_NONSEQ;
        @(negedge hclk);
        hsel = 1'b0; htrans = TRANS_IDLE; hwdata = 32'h0BADBAD0;
        checks++; if (hreadyout2 !== 1'b0) begin errors++; $display("FAIL reset_mid first_wait hreadyout got %b exp 0", hreadyout2); end
        @(negedge hclk);
        hresetn = 1'b0;
        #1;
        checks++; if (hreadyout2 !== 1'b1) begin errors++; $display("FAIL reset_mid hreadyout got %b exp 1", hreadyout2); end
        checks++; if (hresp2 !== 1'b0)     begin errors++; $display("FAIL reset_mid hresp got %b exp 0", hresp2); end
        checks++; if (hrdata2 !== 32'h0)   begin errors++; $display("FAIL reset_mid hrdata got %h exp 0", hrdata2); end
        @(negedge hclk);
        hresetn = 1'b1;
        add(0, 32'h40, SIZE_WORD, 32'h0);
        run_seq("reset_readback");

        sel2 = 1'b0;
        hsel = 1'b1; haddr = 32'h2000; hwrite = 1'b0; hsize = SIZE_WORD; htrans = TRANS_NONSEQ;
        @(negedge hclk);
        hsel = 1'b0; htrans = TRANS_IDLE;
        checks++; if (hresp0 !== 1'b1)     begin errors++; $display("FAIL reset_err err1_hresp got %b exp 1", hresp0); end
        checks++; if (hreadyout0 !== 1'b0) begin errors++; $display("FAIL reset_err err1_hreadyout got %b exp 0", hreadyout0); end
        hresetn = 1'b0;
        #1;
        checks++; if (hresp0 !== 1'b0)     begin errors++; $display("FAIL reset_err hresp got %b exp 0", hresp0); end
        checks++; if (hreadyout0 !== 1'b1) begin errors++; $display("FAIL reset_err hreadyout got %b exp 1", hreadyout0); end
        @(negedge hclk);
        hresetn = 1'b1;
        add(0, 32'h10, SIZE_WORD, 32'h0);
        run_seq("reset_err_readback");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        hresetn = 1'b0; hsel = 1'b0; haddr = '0; htrans = TRANS_IDLE; hwrite = 1'b0;
        hsize = SIZE_WORD; hburst = 3'b000; hprot = 4'b0011; hwdata = '0;
        hready_low = 1'b0; sel2 = 1'b0;
        repeat (3) @(negedge hclk);
        test_reset();
        hresetn = 1'b1;
        @(negedge hclk);
        test_zero_wait();
        test_wait_states();
        test_byte_lanes();
        test_errors();
        test_burst_stall();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahb_lite_mem_slave.md
AHB_LITE_MEM_SLAVE -- requirements
Module: ahb_lite_mem_slave

Interface
REQ-001 Parameter DATA_W, default 32, data bus width in bits (32 or 64).
REQ-002 Parameter ADDR_W, default 32, address bus width in bits.
REQ-003 Parameter DEPTH, default 1024, memory size in DATA_W-bit words (power of 2).
REQ-004 Parameter WAIT_STATES, default 0, data-phase wait cycles per transfer (0..7).
REQ-005 Parameter BASE_ADDR, default 0, byte address of word 0 (aligned to DEPTH*DATA_W/8).
REQ-006 hclk  in  1  clock; all state changes on rising edge.
REQ-007 hresetn  in  1  reset, asynchronous, active-low.
REQ-008 hsel  in  1  slave select, address phase.
REQ-009 haddr  in  ADDR_W  byte address, address phase.
REQ-010 htrans  in  2  IDLE/BUSY/NONSEQ/SEQ.
REQ-011 hwrite  in  1  1=write, 0=read.
REQ-012 hsize  in  3  transfer size (byte..DATA_W).
REQ-013 hburst  in  3  burst type; accepted, not decoded.
REQ-014 hprot  in  4  protection; accepted, not decoded.
REQ-015 hwdata  in  DATA_W  write data, data phase.
REQ-016 hready  in  1  bus-level ready from the interconnect.
REQ-017 hreadyout  out  1  slave ready; 0 extends data phase.
REQ-018 hresp  out  1  0=OKAY, 1=ERROR.
REQ-019 hrdata  out  DATA_W  read data, valid when hreadyout=1 in a read data phase.

Function
REQ-020 Transfer accepted when hsel=1, hready=1, htrans in {NONSEQ,SEQ} at a rising edge; haddr/hwrite/hsize registered then.
REQ-021 IDLE/BUSY or hsel=0 transfers SHALL get a zero-wait OKAY (hreadyout=1, hresp=0).
REQ-022 FSM states IDLE, DATA, ERR1, ERR2; IDLE->DATA on valid accepted transfer; IDLE->ERR1 on invalid accepted transfer.
REQ-023 DATA: wait counter counts 0..WAIT_STATES; hreadyout=0 while count<WAIT_STATES, 1 at count=WAIT_STATES.
REQ-024 On DATA completion: new accepted transfer -> DATA (count=0) or ERR1; else -> IDLE.
REQ-025 Invalid = address outside [BASE_ADDR, BASE_ADDR+DEPTH*DATA_W/8), hsize wider than DATA_W, or haddr not aligned to hsize.
REQ-026 ERR1: hreadyout=0, hresp=1; ERR2 (next cycle): hreadyout=1, hresp=1; then IDLE or next transfer as REQ-024.
REQ-027 Errored writes SHALL NOT modify memory; errored reads drive hrdata=0.
REQ-028 Writes: only byte lanes selected by hsize and haddr[log2(DATA_W/8)-1:0] (little-endian) updated, from hwdata sampled on completing edge.
REQ-029 Reads: hrdata = full word at registered address; unselected lanes carry memory contents.
REQ-030 Write followed by read of same address back-to-back SHALL return the newly written data.
REQ-031 hready=0 from another slave SHALL NOT accept a new transfer; pending state unchanged.

Reset
REQ-032 hresetn=0 forces IDLE, count=0, hreadyout=1, hresp=0, hrdata=0, asynchronously, including mid-wait or mid-ERROR.
REQ-033 Memory contents SHALL NOT be reset; in-flight write discarded.

Structure
REQ-034 Package ahb_lite_pkg holds htrans_t, hsize_t, hresp_t enums and FSM state_t typedef.
REQ-035 Sub-module ahb_lite_mem_array: DEPTH x DATA_W array, byte-enable write port, asynchronous read port.

Verification
REQ-036 WAIT_STATES=0: write 0xDEADBEEF @0x10, read @0x10 next -> hrdata=0xDEADBEEF, hreadyout never 0.
REQ-037 WAIT_STATES=2: single read -> hreadyout low exactly 2 cycles, then 1 with data, hresp=0.
REQ-038 Byte write 0xAA @0x13 over 0x00000000 -> word read 0xAA000000.
REQ-039 Read @BASE_ADDR+DEPTH*4 -> hreadyout 0/1, hresp 1/1 over two cycles, hrdata=0; halfword @0x01 -> same ERROR.
REQ-040 hresetn low during second wait cycle -> hreadyout=1, hresp=0 immediately; target word unchanged.
REQ-041 INCR4 SEQ write burst 0x20..0x2C with hready toggled by interconnect -> all four words read back correctly.
